// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller, ALU and datapath.
// CONTROL_FSM_ILLEGAL_TRAP_EN adds the TRAP state to the state encoding.
package control_fsm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_DIRECT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_LUI, S_ALU_WB, S_JAL, S_JALR, S_JAL_LINK, S_BRANCH
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLASS_ADD, ALU_CLASS_R, ALU_CLASS_I, ALU_CLASS_BR
  } alu_class_t;

  // blt/bltu take on a nonzero compare result, bge/bgeu on zero
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000, 3'b101, 3'b111: branch_taken = zero;
      3'b001, 3'b100, 3'b110: branch_taken = ~zero;
      default:                branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// Combinational ALU op select from the controller's state class and the
// latched funct3/funct7b5 fields.
module control_fsm_alu_decoder
  import control_fsm_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_class)
      ALU_CLASS_R, ALU_CLASS_I: begin
        case (funct3)
          // immediate ops have no SUB; funct7b5 is an imm bit there
          3'b000: alu_op = (alu_class == ALU_CLASS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      ALU_CLASS_BR: begin
        case (funct3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I main controller. Optional CONTROL_FSM_ILLEGAL_TRAP_EN
// adds the illegal_insn output and a TRAP state left only through rst.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  , output logic     illegal_insn
`endif
);

  state_t     state;
  alu_class_t alu_class;
  logic       pc_en, ir_en, mem_we, reg_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEM_ADR;
            OP_R:              state <= S_EXEC_R;
            OP_I:              state <= S_EXEC_I;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            OP_BRANCH:         state <= (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
`else
            OP_BRANCH:         state <= S_BRANCH;
`endif
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI:            state <= S_LUI;
            OP_AUIPC:          state <= S_ALU_WB;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            default:           state <= S_TRAP;
`else
            default:           state <= S_FETCH;
`endif
          endcase
        end
        S_MEM_ADR:   state <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_LUI, S_JAL: state <= S_ALU_WB;
        S_JALR:      state <= S_JAL_LINK;
        S_JAL_LINK:  state <= S_ALU_WB;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        S_TRAP:      state <= S_TRAP;
`endif
        default:     state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALU_OUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_class  = ALU_CLASS_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU_DIRECT;
        ir_en      = mem_ready;
        pc_en      = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = RES_MEM_DATA;
        reg_we     = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_class = ALU_CLASS_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_class = ALU_CLASS_I;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
      end
      S_ALU_WB: reg_we = 1'b1;
      S_JAL: begin
        pc_en     = 1'b1;
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_FOUR;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU_DIRECT;
        pc_en      = 1'b1;
      end
      S_JAL_LINK: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_FOUR;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_class = ALU_CLASS_BR;
        pc_en     = branch_taken(funct3, zero);
      end
      default: ;
    endcase
  end

  // rst gates the enables combinationally so the reset cycle never writes
  assign pc_write  = pc_en  & ~rst;
  assign ir_write  = ir_en  & ~rst;
  assign mem_write = mem_we & ~rst;
  assign reg_write = reg_we & ~rst;

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  assign illegal_insn = (state == S_TRAP);
`endif

  control_fsm_alu_decoder u_alu_decoder (
    .alu_class (alu_class),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .alu_op    (alu_op)
  );

endmodule

// File: tb/tb_control_fsm.sv
// Randomized check of control_fsm against an instruction-level model that
// expands each instruction into its expected per-cycle control outputs.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_op;
  logic       ill;

  control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op)
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    , .illegal_insn(ill)
`endif
  );

`ifndef CONTROL_FSM_ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mr;
    logic        z;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [15:0] exp;
    logic [15:0] mask;
    string       tag;
  } cyc_t;

  cyc_t       q[$];
  int         total = 0;
  int         bad = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // {illegal, pc_write, ir_write, adr_src, mem_write, reg_write, result_src, a, b, alu_op}
  function automatic logic [15:0] ov(input logic pw, iw, adr, mw, rw,
                                     input logic [1:0] rs, a, b, input logic [3:0] alu);
    return {1'b0, pw, iw, adr, mw, rw, rs, a, b, alu};
  endfunction

  function automatic logic [3:0] ref_alu(input int kind, input logic [2:0] f3, input logic f7);
    if (kind == 2) begin
      if (f3 == 3'd4 || f3 == 3'd5) return 4'd2;
      if (f3 == 3'd6 || f3 == 3'd7) return 4'd3;
      return 4'd1;
    end
    case (f3)
      3'd0: return (kind == 0 && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd8;
      3'd2: return 4'd2;
      3'd3: return 4'd3;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd10 : 4'd9;
      3'd6: return 4'd5;
      default: return 4'd6;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z);
    if (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) return z;
    if (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) return !z;
    return 1'b0;
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  task automatic push_full(input string tag, input logic r, input logic mr, input logic z,
                           input logic [15:0] exp, input logic [15:0] mask);
    cyc_t c;
    c.rst = r; c.mr = mr; c.z = z; c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
    c.exp = exp; c.mask = mask; c.tag = tag;
    q.push_back(c);
  endtask

  task automatic push(input string tag, input logic mr, input logic [15:0] exp);
    push_full(tag, 1'b0, mr, rb(), exp, 16'hFFFF);
  endtask

  task automatic push_trap();
    for (int i = 0; i < 3; i++) push("trap", rb(), 16'h8000);
    push_full("trap_rst", 1'b1, rb(), rb(), 16'h8000, 16'hFFFF);
  endtask

  task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input int nf, input int nm);
    int wf, wm;
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    wf = (nf < 0) ? int'($urandom_range(0, 2)) : nf;
    wm = (nm < 0) ? int'($urandom_range(0, 2)) : nm;
    for (int i = 0; i < wf; i++) push("fetch_wait", 1'b0, ov(0, 0, 0, 0, 0, 2, 0, 2, 0));
    push("fetch", 1'b1, ov(1, 1, 0, 0, 0, 2, 0, 2, 0));
    push("decode", rb(), ov(0, 0, 0, 0, 0, 0, 1, 1, 0));
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    if (!known_op(op) || (op == 7'b1100011 && f3[2:1] == 2'b01)) begin
      push_trap();
      return;
    end
`endif
    case (op)
      7'b0000011: begin
        push("mem_adr", rb(), ov(0, 0, 0, 0, 0, 0, 2, 1, 0));
        for (int i = 0; i < wm; i++) push("mem_read_wait", 1'b0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0));
        push("mem_read", 1'b1, ov(0, 0, 1, 0, 0, 0, 0, 0, 0));
        push("mem_wb", rb(), ov(0, 0, 0, 0, 1, 1, 0, 0, 0));
      end
      7'b0100011: begin
        push("mem_adr", rb(), ov(0, 0, 0, 0, 0, 0, 2, 1, 0));
        for (int i = 0; i < wm; i++) push("mem_write_wait", 1'b0, ov(0, 0, 1, 1, 0, 0, 0, 0, 0));
        push("mem_write", 1'b1, ov(0, 0, 1, 1, 0, 0, 0, 0, 0));
      end
      7'b0110011: begin
        push("exec_r", rb(), ov(0, 0, 0, 0, 0, 0, 2, 0, ref_alu(0, f3, f7)));
        push("alu_wb", rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      7'b0010011: begin
        push("exec_i", rb(), ov(0, 0, 0, 0, 0, 0, 2, 1, ref_alu(1, f3, f7)));
        push("alu_wb", rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      7'b1100011: begin
        // alu_op for the reserved funct3 codes is left unconstrained
        push_full("branch", 1'b0, rb(), z,
                  ov(ref_taken(f3, z), 0, 0, 0, 0, 0, 2, 0, ref_alu(2, f3, f7)),
                  (f3[2:1] == 2'b01) ? 16'hFFF0 : 16'hFFFF);
      end
      7'b1101111: begin
        push("jal", rb(), ov(1, 0, 0, 0, 0, 0, 1, 2, 0));
        push("alu_wb", rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      7'b1100111: begin
        push("jalr", rb(), ov(1, 0, 0, 0, 0, 2, 2, 1, 0));
        push("jal_link", rb(), ov(0, 0, 0, 0, 0, 0, 1, 2, 0));
        push("alu_wb", rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      7'b0110111: begin
        push("lui", rb(), ov(0, 0, 0, 0, 0, 0, 3, 1, 0));
        push("alu_wb", rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      7'b0010111: push("alu_wb", rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      default: ;
    endcase
  endtask

  task automatic gen_store_reset();
    cur_op = 7'b0100011; cur_f3 = 3'd2; cur_f7 = 1'b0;
    push("fetch", 1'b1, ov(1, 1, 0, 0, 0, 2, 0, 2, 0));
    push("decode", rb(), ov(0, 0, 0, 0, 0, 0, 1, 1, 0));
    push("mem_adr", rb(), ov(0, 0, 0, 0, 0, 0, 2, 1, 0));
    push("mem_write_wait", 1'b0, ov(0, 0, 1, 1, 0, 0, 0, 0, 0));
    push_full("mem_write_rst", 1'b1, 1'b1, rb(), ov(0, 0, 1, 0, 0, 0, 0, 0, 0), 16'hFFFF);
  endtask

  task automatic run_queue();
    cyc_t c;
    logic [15:0] obs;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst = c.rst; mem_ready = c.mr; zero = c.z;
      opcode = c.op; funct3 = c.f3; funct7b5 = c.f7;
      #1;
      obs = {ill, pc_write, ir_write, adr_src, mem_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op};
      chk(c.tag, 32'(obs & c.mask), 32'(c.exp & c.mask));
    end
  endtask

  logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int k;
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0;
    @(posedge clk);
    // ready held high in reset: fetch enables must still stay low
    push_full("reset", 1'b1, 1'b1, 1'b0, ov(0, 0, 0, 0, 0, 2, 0, 2, 0), 16'hFFFF);
    push_full("reset", 1'b1, 1'b1, 1'b1, ov(0, 0, 0, 0, 0, 2, 0, 2, 0), 16'hFFFF);
    gen(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
    gen(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
    gen(7'b0110011, 3'd5, 1'b1, 1'b0, 0, 0);
    gen(7'b0010011, 3'd5, 1'b1, 1'b0, 0, 0);
    gen(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
    gen(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3);
    gen(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
    gen(7'b1100011, 3'd5, 1'b0, 1'b0, 0, 0);
    gen(7'b1100011, 3'd6, 1'b0, 1'b1, 0, 0);
    gen(7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0);
    gen(7'b1100011, 3'd2, 1'b0, 1'b1, 0, 0);
    gen_store_reset();
    gen(7'b0000000, 3'd0, 1'b0, 1'b0, 1, 0);
    run_queue();
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 9));
      op = (k == 9) ? 7'b1111111 : ops[k];
      f3 = (op == 7'b1100011) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      gen(op, f3, rb(), rb(), -1, -1);
      run_queue();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
